tt_vec_mul_ctrl: RTL and testbench
==================================

TT_VEC_MUL_CTRL -- requirements
Module: tt_vec_mul_ctrl

Interface
REQ-001 SHALL have parameter VLEN, default 256, vector register width in bits; lane count L = VLEN/8.
REQ-002 SHALL have port i_clk, input, 1 bit, the single clock.
REQ-003 SHALL have port i_reset, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port i_req_valid, input, 1 bit, multiply request valid.
REQ-005 SHALL have port o_req_ready, output, 1 bit, request accepted when i_req_valid && o_req_ready.
REQ-006 SHALL have port i_req_op, input, 2 bits: 00 MUL (low half, signed), 01 MULH (ss), 10 MULHU (uu), 11 MULHSU (src1 signed, src2 unsigned).
REQ-007 SHALL have port i_req_sew, input, 2 bits: 0 = 8, 1 = 16, 2 = 32, 3 = 64-bit elements.
REQ-008 SHALL have port i_req_tag, input, 4 bits, opaque ID returned with the response.
REQ-009 SHALL have port i_flush, input, 1 bit, discards any pending response.
REQ-010 SHALL have ports o_mulen_0a, o_issgn_0a and o_issgnsrc2_0a, outputs, 1 bit each, driving the multiply datapath enable, src1-signed and src2-signed controls.
REQ-011 SHALL have port i_sum_1a, input, L x 129 bits, datapath products, valid one cycle after o_mulen_0a and held while o_mulen_0a is low.
REQ-012 SHALL have port o_rsp_valid, input i_rsp_ready, 1 bit each, response handshake.
REQ-013 SHALL have ports o_rsp_data (output, L x 64 bits, per-lane result) and o_rsp_tag (output, 4 bits).

Function
REQ-014 SHALL implement two states: EMPTY (no result pending) and FULL (result in datapath awaiting handshake); o_rsp_valid SHALL equal (state == FULL).
REQ-015 o_req_ready SHALL be !i_flush && (EMPTY || i_rsp_ready), giving one op per cycle at full throughput.
REQ-016 o_mulen_0a SHALL equal i_req_valid && o_req_ready in the same cycle; latency from accept to o_rsp_valid SHALL be exactly 1 cycle.
REQ-017 Sign controls: o_issgn_0a = (op != 10); o_issgnsrc2_0a = (op == 00 || op == 01); both SHALL be 0 when o_mulen_0a is 0.
REQ-018 On accept, op, sew and tag SHALL be registered and the state SHALL go to FULL; with no accept, FULL && i_rsp_ready SHALL go to EMPTY; otherwise the state is held.
REQ-019 Active lane ranges: SEW8 lanes L/2..L-1; SEW16 L/4..L/2-1; SEW32 L/8..L/4-1; SEW64 0..L/8-1.
REQ-020 For an active lane with width S, o_rsp_data[i] SHALL be i_sum_1a[i][S-1:0] for MUL and i_sum_1a[i][2S-1:S] for MULH/MULHU/MULHSU, zero-extended to 64 bits; inactive lanes SHALL be 0.
REQ-021 o_rsp_data and o_rsp_tag SHALL be 0 whenever o_rsp_valid is 0.
REQ-022 i_flush SHALL force the state to EMPTY at the next edge, block accepts that cycle, and take priority over i_rsp_ready.
REQ-023 An accept in the same cycle as a response handshake SHALL leave the state FULL with the new op's registered fields.

Reset
REQ-024 On i_reset at a clock edge: state SHALL be EMPTY, registered op/sew/tag SHALL be 0, and perf counters SHALL be 0.
REQ-025 During reset cycles, o_req_ready, o_mulen_0a and o_rsp_valid SHALL be 0; a FULL result in flight at reset SHALL be dropped.

Configuration
REQ-026 With macro TT_VEC_MUL_CTRL_PERF_EN defined, outputs o_perf_ops[31:0] (accepted requests) and o_perf_stall[31:0] (cycles with o_rsp_valid && !i_rsp_ready) SHALL be present; both SHALL be saturating counters cleared by i_reset.
REQ-027 Without TT_VEC_MUL_CTRL_PERF_EN, both ports SHALL still exist and be tied to 0, with no counter flops.

Verification
REQ-028 MUL, SEW8, lane L-1 sum 0x0FE01 (0xFF*0xFF unsigned path), tag 5 -> 1 cycle later o_rsp_valid=1, lane L-1 data 0x01, tag 5, o_issgn_0a=1 and o_issgnsrc2_0a=1 at issue.
REQ-029 MULHU, SEW32, lane L/8 sum 0x0_FFFFFFFE_00000001 -> data 0xFFFFFFFE; o_issgn_0a=0 and o_issgnsrc2_0a=0 at issue; lane 0 data 0.
REQ-030 Back-to-back: 4 requests on consecutive cycles with i_rsp_ready=1 -> 4 responses on consecutive cycles, in order, tags 0..3.
REQ-031 Backpressure: FULL, i_rsp_ready=0 for 3 cycles -> o_req_ready=0, o_mulen_0a=0, data and tag stable; perf stall count +3 when the macro is enabled.
REQ-032 Flush while FULL with i_req_valid=1 -> no accept; next cycle o_rsp_valid=0; the following request completes normally.
REQ-033 Reset asserted while FULL -> next cycle o_rsp_valid=0, state EMPTY, o_perf_ops=0.

Source files
------------

// File: rtl/tt_vec_mul_ctrl.sv
// Vector multiply control: issues one op per cycle to the datapath and returns per-lane results one cycle later.
// Optional perf counters are enabled with TT_VEC_MUL_CTRL_PERF_EN; otherwise the perf ports are tied to 0.
module tt_vec_mul_ctrl #(
    parameter int VLEN = 256
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_req_valid,
    output logic                        o_req_ready,
    input  logic [1:0]                  i_req_op,
    input  logic [1:0]                  i_req_sew,
    input  logic [3:0]                  i_req_tag,
    input  logic                        i_flush,
    output logic                        o_mulen_0a,
    output logic                        o_issgn_0a,
    output logic                        o_issgnsrc2_0a,
    input  logic [VLEN/8-1:0][128:0]    i_sum_1a,
    output logic                        o_rsp_valid,
    input  logic                        i_rsp_ready,
    output logic [VLEN/8-1:0][63:0]     o_rsp_data,
    output logic [3:0]                  o_rsp_tag,
    output logic [31:0]                 o_perf_ops,
    output logic [31:0]                 o_perf_stall
);
    localparam int L = VLEN / 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] op_q, op_d;
    logic [1:0] sew_q, sew_d;
    logic [3:0] tag_q, tag_d;
    logic       accept;

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        sew_d          = sew_q;
        tag_d          = tag_q;
        o_req_ready    = !i_reset && !i_flush && ((state_q == EMPTY) || i_rsp_ready);
        accept         = i_req_valid && o_req_ready;
        o_mulen_0a     = accept;
        o_issgn_0a     = accept && (i_req_op != 2'b10);
        o_issgnsrc2_0a = accept && ((i_req_op == 2'b00) || (i_req_op == 2'b01));
        o_rsp_valid    = (state_q == FULL) && !i_reset;
        o_rsp_tag      = o_rsp_valid ? tag_q : 4'd0;
        // Flush wins over both a new accept and a response handshake.
        if (i_flush) begin
            state_d = EMPTY;
        end else if (accept) begin
            state_d = FULL;
            op_d    = i_req_op;
            sew_d   = i_req_sew;
            tag_d   = i_req_tag;
        end else if ((state_q == FULL) && i_rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= EMPTY;
            op_q    <= 2'd0;
            sew_q   <= 2'd0;
            tag_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sew_q   <= sew_d;
            tag_q   <= tag_d;
        end
    end

    // Each lane belongs to exactly one element width, so the slice bounds are fixed per lane.
    for (genvar i = 0; i < L; i++) begin : g_lane
        localparam logic [1:0] LANE_SEW = (i >= L/2) ? 2'd0 :
                                          (i >= L/4) ? 2'd1 :
                                          (i >= L/8) ? 2'd2 : 2'd3;
        localparam int S = 8 << LANE_SEW;
        logic [63:0] lo_res;
        logic [63:0] hi_res;
        assign lo_res        = 64'(i_sum_1a[i][S-1:0]);
        assign hi_res        = 64'(i_sum_1a[i][2*S-1:S]);
        assign o_rsp_data[i] = (o_rsp_valid && (sew_q == LANE_SEW)) ?
                               ((op_q == 2'b00) ? lo_res : hi_res) : 64'd0;
    end

    logic unused_sum;
    assign unused_sum = ^i_sum_1a;

`ifdef TT_VEC_MUL_CTRL_PERF_EN
    logic [31:0] perf_ops_q, perf_ops_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_ops_d   = perf_ops_q;
        perf_stall_d = perf_stall_q;
        if (accept && (perf_ops_q != 32'hFFFF_FFFF)) begin
            perf_ops_d = perf_ops_q + 32'd1;
        end
        if (o_rsp_valid && !i_rsp_ready && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            perf_ops_q   <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            perf_ops_q   <= perf_ops_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign o_perf_ops   = perf_ops_q;
    assign o_perf_stall = perf_stall_q;
`else
    assign o_perf_ops   = 32'd0;
    assign o_perf_stall = 32'd0;
`endif

endmodule

// File: tb/tb_tt_vec_mul_ctrl.sv
// Bench for tt_vec_mul_ctrl: directed scenarios then random traffic, checked against a transaction-level model.
module tb_tt_vec_mul_ctrl;
    localparam int VLEN = 256;
    localparam int L    = VLEN / 8;

    logic                   i_clk;
    logic                   i_reset;
    logic                   i_req_valid;
    logic                   o_req_ready;
    logic [1:0]             i_req_op;
    logic [1:0]             i_req_sew;
    logic [3:0]             i_req_tag;
    logic                   i_flush;
    logic                   o_mulen_0a;
    logic                   o_issgn_0a;
    logic                   o_issgnsrc2_0a;
    logic [L-1:0][128:0]    i_sum_1a;
    logic                   o_rsp_valid;
    logic                   i_rsp_ready;
    logic [L-1:0][63:0]     o_rsp_data;
    logic [3:0]             o_rsp_tag;
    logic [31:0]            o_perf_ops;
    logic [31:0]            o_perf_stall;

    tt_vec_mul_ctrl #(.VLEN(VLEN)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_op       (i_req_op),
        .i_req_sew      (i_req_sew),
        .i_req_tag      (i_req_tag),
        .i_flush        (i_flush),
        .o_mulen_0a     (o_mulen_0a),
        .o_issgn_0a     (o_issgn_0a),
        .o_issgnsrc2_0a (o_issgnsrc2_0a),
        .i_sum_1a       (i_sum_1a),
        .o_rsp_valid    (o_rsp_valid),
        .i_rsp_ready    (i_rsp_ready),
        .o_rsp_data     (o_rsp_data),
        .o_rsp_tag      (o_rsp_tag),
        .o_perf_ops     (o_perf_ops),
        .o_perf_stall   (o_perf_stall)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: one pending transaction plus perf counts.
    bit                  m_full;
    logic [1:0]          m_op, m_sew;
    logic [3:0]          m_tag;
    int unsigned         m_ops, m_stall;
    logic [L-1:0][128:0] cur_sum, next_sum;
    bit                  e_accept, e_vld;
    bit                  d_rst, d_flush, d_rdy;
    logic [1:0]          d_op, d_sew;
    logic [3:0]          d_tag;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    function automatic logic [128:0] rnd129();
        return {1'($urandom), $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic new_sum();
        for (int i = 0; i < L; i++) next_sum[i] = rnd129();
    endtask

    function automatic logic [63:0] exp_lane(input bit vld, input int i);
        int s, lo, hi;
        logic [128:0] v, mask;
        if (!vld) return 64'd0;
        s = 8 << m_sew;
        if (m_sew == 2'd3) begin
            lo = 0;
            hi = L / 8;
        end else begin
            hi = L >> m_sew;
            lo = L >> (m_sew + 1);
        end
        if (i < lo || i >= hi) return 64'd0;
        v    = cur_sum[i];
        if (m_op != 2'b00) v = v >> s;
        mask = (129'd1 << s) - 129'd1;
        v    = v & mask;
        return v[63:0];
    endfunction

    task automatic drive(input bit rst, input bit valid, input logic [1:0] op, input logic [1:0] sew,
                         input logic [3:0] tag, input bit flush, input bit rdy);
        bit e_ready;
        bit data_bad;
        logic [L-1:0][63:0] ed;
        i_reset     = rst;
        i_req_valid = valid;
        i_req_op    = op;
        i_req_sew   = sew;
        i_req_tag   = tag;
        i_flush     = flush;
        i_rsp_ready = rdy;
        d_rst = rst; d_flush = flush; d_rdy = rdy; d_op = op; d_sew = sew; d_tag = tag;
        #2;
        e_ready  = !rst && !flush && (!m_full || rdy);
        e_accept = valid && e_ready;
        e_vld    = m_full && !rst;
        chk("req_ready", o_req_ready, e_ready);
        chk("mulen", o_mulen_0a, e_accept);
        chk("issgn", o_issgn_0a, e_accept && (op != 2'b10));
        chk("issgnsrc2", o_issgnsrc2_0a, e_accept && (op == 2'b00 || op == 2'b01));
        chk("rsp_valid", o_rsp_valid, e_vld);
        chk("rsp_tag", o_rsp_tag, e_vld ? m_tag : 4'd0);
        for (int i = 0; i < L; i++) ed[i] = exp_lane(e_vld, i);
        n_cmp++;
        assert (o_rsp_data === ed) else begin
            n_fail++;
            data_bad = 1'b0;
            for (int i = 0; i < L; i++) begin
                if (!data_bad && o_rsp_data[i] !== ed[i]) begin
                    data_bad = 1'b1;
                    $error("FAIL rsp_data lane %0d observed=0x%0h expected=0x%0h", i, o_rsp_data[i], ed[i]);
                end
            end
        end
`ifdef TT_VEC_MUL_CTRL_PERF_EN
        chk("perf_ops", o_perf_ops, m_ops);
        chk("perf_stall", o_perf_stall, m_stall);
`else
        chk("perf_ops", o_perf_ops, 64'd0);
        chk("perf_stall", o_perf_stall, 64'd0);
`endif
    endtask

    task automatic tick();
        @(posedge i_clk);
        if (d_rst) begin
            m_full = 1'b0; m_op = 2'd0; m_sew = 2'd0; m_tag = 4'd0;
            m_ops  = 0;    m_stall = 0;
        end else begin
            if (e_vld && !d_rdy) m_stall++;
            if (e_accept) m_ops++;
            if (d_flush) begin
                m_full = 1'b0;
            end else if (e_accept) begin
                m_full  = 1'b1;
                m_op    = d_op;
                m_sew   = d_sew;
                m_tag   = d_tag;
                cur_sum = next_sum;
            end else if (m_full && d_rdy) begin
                m_full = 1'b0;
            end
        end
        #1;
        i_sum_1a = cur_sum;
    endtask

    initial begin
        new_sum();
        cur_sum     = next_sum;
        i_sum_1a    = cur_sum;
        i_reset     = 1'b1;
        i_req_valid = 1'b0;
        i_req_op    = 2'd0;
        i_req_sew   = 2'd0;
        i_req_tag   = 4'd0;
        i_flush     = 1'b0;
        i_rsp_ready = 1'b0;
        m_full = 1'b0; m_op = 2'd0; m_sew = 2'd0; m_tag = 4'd0; m_ops = 0; m_stall = 0;
        repeat (2) @(posedge i_clk);
        #1;
        // Reset still asserted with a valid request: nothing may be accepted.
        drive(1, 1, 2'd0, 2'd0, 4'd0, 0, 1);
        tick();

        // MUL SEW8, lane L-1 product 0xFF*0xFF.
        new_sum();
        next_sum[L-1] = 129'h0FE01;
        drive(0, 1, 2'b00, 2'd0, 4'd5, 0, 1);
        chk("r28_issgn", o_issgn_0a, 1);
        chk("r28_issgnsrc2", o_issgnsrc2_0a, 1);
        tick();
        drive(0, 0, 2'd0, 2'd0, 4'd0, 0, 1);
        chk("r28_valid", o_rsp_valid, 1);
        chk("r28_data", o_rsp_data[L-1], 64'h01);
        chk("r28_tag", o_rsp_tag, 4'd5);
        tick();

        // MULHU SEW32, lane L/8.
        new_sum();
        next_sum[L/8] = 129'h0_FFFFFFFE_00000001;
        drive(0, 1, 2'b10, 2'd2, 4'd3, 0, 1);
        chk("r29_issgn", o_issgn_0a, 0);
        chk("r29_issgnsrc2", o_issgnsrc2_0a, 0);
        tick();
        drive(0, 0, 2'd0, 2'd0, 4'd0, 0, 1);
        chk("r29_data", o_rsp_data[L/8], 64'hFFFF_FFFE);
        chk("r29_lane0", o_rsp_data[0], 64'd0);
        tick();

        // Back-to-back issue with a ready consumer.
        for (int k = 0; k < 4; k++) begin
            new_sum();
            drive(0, 1, 2'($urandom), 2'($urandom), 4'(k), 0, 1);
            if (k > 0) chk("b2b_tag", o_rsp_tag, 64'(k - 1));
            tick();
        end
        drive(0, 0, 2'd0, 2'd0, 4'd0, 0, 1);
        chk("b2b_last_tag", o_rsp_tag, 4'd3);
        tick();

        // Backpressure for three cycles.
        new_sum();
        drive(0, 1, 2'b01, 2'd1, 4'd9, 0, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 2'b00, 2'd0, 4'd1, 0, 0);
            chk("bp_ready", o_req_ready, 0);
            tick();
        end
        drive(0, 0, 2'd0, 2'd0, 4'd0, 0, 1);
        tick();

        // Flush while FULL with a request pending.
        new_sum();
        drive(0, 1, 2'b11, 2'd3, 4'd7, 0, 0);
        tick();
        drive(0, 1, 2'b00, 2'd0, 4'd8, 1, 1);
        chk("flush_mulen", o_mulen_0a, 0);
        tick();
        new_sum();
        drive(0, 1, 2'b00, 2'd3, 4'd9, 0, 1);
        chk("flush_after_valid", o_rsp_valid, 0);
        tick();
        drive(0, 0, 2'd0, 2'd0, 4'd0, 0, 1);
        chk("flush_next_tag", o_rsp_tag, 4'd9);
        tick();

        // Reset while FULL.
        new_sum();
        drive(0, 1, 2'b01, 2'd0, 4'd4, 0, 0);
        tick();
        drive(1, 1, 2'b00, 2'd0, 4'd2, 0, 0);
        tick();
        drive(0, 0, 2'd0, 2'd0, 4'd0, 0, 1);
        chk("rst_valid", o_rsp_valid, 0);
        chk("rst_ops", o_perf_ops, 0);
        tick();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            new_sum();
            drive($urandom_range(31, 0) == 0, $urandom_range(9, 0) < 7, 2'($urandom), 2'($urandom),
                  4'($urandom), $urandom_range(9, 0) == 0, $urandom_range(9, 0) < 7);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
